// File: rtl/vp2_pkg.sv
// Shared motion-core definitions: divider arbiter FSM states and datapath widths.
package vp2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ZERO = 2'd2
    } state_e;

    localparam int DIV_W = 32;
    localparam int QUO_W = 64;

    localparam logic [QUO_W-1:0] QUO_SAT = '1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index strictly after `last`, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  pending,
    input  logic [LW-1:0] last,
    output logic          valid,
    output logic [LW-1:0] winner
);

    int   idx;
    logic found;

    always_comb begin
        valid  = |pending;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && pending[idx]) begin
                winner = LW'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider between N_REQ DDA engines with round-robin grants.
module div_arbiter
    import vp2_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int LW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ*DIV_W-1:0] req_divident,
    input  logic [N_REQ*DIV_W-1:0] req_divisor,
    input  logic [N_REQ-1:0]       req_start,
    output logic [QUO_W-1:0]       req_quotinent,
    output logic [N_REQ-1:0]       req_done,
    output logic [DIV_W-1:0]       div_divident,
    output logic [DIV_W-1:0]       div_divisor,
    output logic                   div_start,
    input  logic [QUO_W-1:0]       div_quotinent,
    input  logic                   div_done,
    output state_e                 fsm_state
);

    // valid/ready: req_start and div_start are single-cycle pulses with no back-pressure;
    // req_done / div_done are single-cycle completion pulses qualifying the quotient.

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] op_dvd [N_REQ];
    logic [DIV_W-1:0] op_dvs [N_REQ];
    logic [N_REQ-1:0] pending;
    logic [LW-1:0]    last_grant;
    logic [LW-1:0]    grant;
    state_e           state;

    logic             pick_valid;
    logic [LW-1:0]    pick_w;
    logic [N_REQ-1:0] grant_mask;

    rr_pick #(.N(N_REQ), .LW(LW)) u_pick (
        .pending (pending),
        .last    (last_grant),
        .valid   (pick_valid),
        .winner  (pick_w)
    );

    assign grant_mask = (state == ST_IDLE && pick_valid) ? (ONE << pick_w) : '0;
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            pending       <= '0;
            last_grant    <= LW'(N_REQ - 1);
            grant         <= '0;
            req_quotinent <= '0;
            req_done      <= '0;
            div_divident  <= '0;
            div_divisor   <= '0;
            div_start     <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                op_dvd[i] <= '0;
                op_dvs[i] <= '0;
            end
        end else begin
            div_start <= 1'b0;
            req_done  <= '0;
            // A new start on the requester being granted re-arms it (set wins over clear).
            pending   <= (pending & ~grant_mask) | req_start;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_start[i]) begin
                    op_dvd[i] <= req_divident[DIV_W*i +: DIV_W];
                    op_dvs[i] <= req_divisor[DIV_W*i +: DIV_W];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        last_grant <= pick_w;
                        grant      <= pick_w;
                        if (op_dvs[pick_w] != '0) begin
                            div_divident <= op_dvd[pick_w];
                            div_divisor  <= op_dvs[pick_w];
                            div_start    <= 1'b1;
                            state        <= ST_WAIT;
                        end else begin
                            req_quotinent <= QUO_SAT;
                            state         <= ST_ZERO;
                        end
                    end
                end
                ST_ZERO: begin
                    req_done <= ONE << grant;
                    state    <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (div_done) begin
                        req_quotinent <= div_quotinent;
                        req_done      <= ONE << grant;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: 5-cycle divider model, operand and completion scoreboards.
module tb_div_arbiter;
    import vp2_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N*32-1:0] req_divident;
    logic [N*32-1:0] req_divisor;
    logic [N-1:0]    req_start = '0;
    logic [63:0]     req_quotinent;
    logic [N-1:0]    req_done;
    logic [31:0]     div_divident;
    logic [31:0]     div_divisor;
    logic            div_start;
    logic [63:0]     div_quotinent = '0;
    logic            div_done = 1'b0;
    state_e          fsm_state;

    logic [31:0] dvd [N];
    logic [31:0] dvs [N];

    logic [67:0] exp_q[$];
    logic [63:0] exp_div_q[$];

    int errors = 0;
    int checks = 0;
    int div_starts = 0;
    int done_cnt = 0;
    logic prev_start = 1'b0;

    logic [63:0] m_q;
    int          m_cnt = 0;

    div_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_divident  (req_divident),
        .req_divisor   (req_divisor),
        .req_start     (req_start),
        .req_quotinent (req_quotinent),
        .req_done      (req_done),
        .div_divident  (div_divident),
        .div_divisor   (div_divisor),
        .div_start     (div_start),
        .div_quotinent (div_quotinent),
        .div_done      (div_done),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_divident[32*i +: 32] = dvd[i];
            req_divisor[32*i +: 32]  = dvs[i];
        end
    end

    // Divider model: result appears 5 cycles after start; not reset by the arbiter reset.
    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start) begin
            m_q   <= (div_divisor == 0) ? 64'd0 : {32'd0, div_divident} / {32'd0, div_divisor};
            m_cnt <= 5;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_done      <= 1'b1;
                div_quotinent <= m_q;
            end
        end
    end

    task automatic check(input string tag, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_start) begin
            div_starts++;
            if (prev_start) check("div_start_gap", 1, 0);
            if (exp_div_q.size() == 0) check("unexpected_div_start", 1, 0);
            else check("div_operands", {4'd0, div_divident, div_divisor}, {4'd0, exp_div_q.pop_front()});
        end
        prev_start = div_start;
        if (req_done != 0) begin
            done_cnt++;
            check("done_onehot", {67'd0, $onehot(req_done)}, 1);
            if (exp_q.size() == 0) check("unexpected_done", {64'd0, req_done}, 0);
            else check("done_result", {req_done, req_quotinent}, exp_q.pop_front());
        end
    end

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        dvd[i] = a;
        dvs[i] = b;
        req_start[i] = 1'b1;
    endtask

    task automatic fire();
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic push_done(input int i, input logic [63:0] q);
        logic [3:0] m;
        m = 4'b0001 << i;
        exp_q.push_back({m, q});
    endtask

    task automatic push_div(input logic [31:0] a, input logic [31:0] b);
        exp_div_q.push_back({a, b});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_start = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && exp_div_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || exp_div_q.size() != 0) begin
            check("drain_timeout", exp_q.size() + exp_div_q.size(), 0);
            exp_q.delete();
            exp_div_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        check("global_timeout", 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int starts_before;
        int done_before;
        for (int i = 0; i < N; i++) begin
            dvd[i] = '0;
            dvs[i] = '0;
        end
        #2;
        check("rst_done", {64'd0, req_done}, 0);
        check("rst_quot", {4'd0, req_quotinent}, 0);
        check("rst_div_start", {67'd0, div_start}, 0);
        do_reset();
        check("idle_state", {66'd0, fsm_state}, {66'd0, ST_IDLE});

        // single request on requester 2
        @(negedge clk);
        set_op(2, 1000, 10);
        push_div(1000, 10);
        push_done(2, 100);
        fire();
        wait_drain();

        // all four at once, fresh round-robin
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_op(i, i * 100, 1);
            push_div(i * 100, 1);
            push_done(i, i * 100);
        end
        fire();
        wait_drain();

        // grant to 1, then 0 and 3 pending: 3 first
        set_op(1, 5000, 7);
        push_div(5000, 7);
        push_done(1, 714);
        fire();
        wait_drain();
        set_op(0, 60, 6);
        set_op(3, 99, 3);
        push_div(99, 3);
        push_div(60, 6);
        push_done(3, 33);
        push_done(0, 10);
        fire();
        wait_drain();

        // zero divisor on requester 1
        starts_before = div_starts;
        set_op(1, 500, 0);
        push_done(1, 64'hFFFF_FFFF_FFFF_FFFF);
        fire();
        @(negedge clk); #2;
        check("zero_early_done", {64'd0, req_done}, 0);
        @(negedge clk); #2;
        check("zero_done_t3", {64'd0, req_done}, {64'd0, 4'b0010});
        check("zero_quot", {4'd0, req_quotinent}, {4'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        wait_drain();
        check("zero_no_div_start", div_starts - starts_before, 0);

        // re-request while in flight
        set_op(0, 77, 7);
        push_div(77, 7);
        push_done(0, 11);
        fire();
        repeat (2) @(negedge clk);
        set_op(0, 80, 4);
        push_div(80, 4);
        push_done(0, 20);
        fire();
        wait_drain();

        // two starts while only pending: last operands win, one completion
        done_before = done_cnt;
        set_op(2, 40, 2);
        push_div(40, 2);
        push_done(2, 20);
        fire();
        repeat (2) @(negedge clk);
        set_op(1, 10, 1);
        fire();
        set_op(1, 90, 3);
        push_div(90, 3);
        push_done(1, 30);
        fire();
        wait_drain();
        check("pending_merge_count", done_cnt - done_before, 2);

        // reset during ST_WAIT with a late div_done
        set_op(3, 50, 5);
        push_div(50, 5);
        fire();
        repeat (2) @(negedge clk);
        check("in_wait", {66'd0, fsm_state}, {66'd0, ST_WAIT});
        reset = 1'b0;
        #1;
        exp_q.delete();
        exp_div_q.delete();
        check("mid_rst_done", {64'd0, req_done}, 0);
        check("mid_rst_quot", {4'd0, req_quotinent}, 0);
        check("mid_rst_divident", {36'd0, div_divident}, 0);
        check("mid_rst_divisor", {36'd0, div_divisor}, 0);
        check("mid_rst_state", {66'd0, fsm_state}, {66'd0, ST_IDLE});
        done_before = done_cnt;
        starts_before = div_starts;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("late_done_ignored", done_cnt - done_before, 0);
        check("no_restart", div_starts - starts_before, 0);
        set_op(2, 49, 7);
        set_op(0, 36, 6);
        push_div(36, 6);
        push_div(49, 7);
        push_done(0, 6);
        push_done(2, 7);
        fire();
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one 32/64-bit sequential divider between N motion-axis DDA engines. Each DDA issues a single-cycle divide request (operands plus start pulse) and waits for a done pulse with the quotient. The arbiter latches these requests, grants the divider round-robin, and routes the result back to the requester. It sits between the per-axis DDA instances and the single divider in the motion core.

## Interface
- N_REQ, 4: number of requesters (2..8)
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- req_divident  input  N_REQ*32  per-requester dividend; slice i = [32*i+31:32*i]
- req_divisor  input  N_REQ*32  per-requester divisor, same slicing
- req_start  input  N_REQ  one-cycle request pulse per requester
- req_quotinent  output  64  registered quotient of the most recently completed request; shared by all requesters
- req_done  output  N_REQ  one-cycle completion pulse, one-hot
- div_divident  output  32  divider dividend, registered
- div_divisor  output  32  divider divisor, registered
- div_start  output  1  one-cycle divider start pulse
- div_quotinent  input  64  divider result
- div_done  input  1  divider completion pulse

## Operation
- **Per-requester state:**
  - operand latch `op_dvd[i]` / `op_dvs[i]` (32b each), loaded on `req_start[i]`
  - `pending[i]`, set on `req_start[i]`
- **FSM (`ST_IDLE`, `ST_WAIT`, `ST_ZERO`):**
  - **ST_IDLE, no pending:** stay in ST_IDLE.
  - **ST_IDLE, any pending:**
    - Pick winner `w` = first pending index strictly after `last_grant`, wrapping modulo N_REQ.
    - Clear `pending[w]` and set `last_grant <= w`.
  - **ST_IDLE, winner divisor != 0:**
    - Register `div_divident <= op_dvd[w]` and `div_divisor <= op_dvs[w]`.
    - Drive `div_start <= 1` for one cycle, then go to ST_WAIT.
  - **ST_IDLE, winner divisor == 0:**
    - Do not touch the divider.
    - Set `req_quotinent <= 64'hFFFF_FFFF_FFFF_FFFF` and go to ST_ZERO.
  - **ST_ZERO:** pulse `req_done[w]`, then go to ST_IDLE.
  - **ST_WAIT:** wait for `div_done`. On it:
    - `req_quotinent <= div_quotinent`
    - `req_done[w] <= 1` for one cycle
    - go to ST_IDLE
- `req_quotinent` holds its value until the next completion. A requester samples it in the cycle its `req_done` bit is high.
- `div_done` is ignored outside ST_WAIT, including a `div_done` from a divide cut off by reset.
- **req_start[i] in the same cycle pending[i] is cleared by a grant:** set wins. The operand latch takes the new values; the granted request uses the old values, registered that same edge.
- **req_start[i] while i is already pending:** operands overwritten, the last one wins, and only one completion is delivered.
- **req_start[i] while i is in flight:** the new request is queued normally. The in-flight result is still delivered with `req_done[i]`.
- **Reset (asynchronous, active-low):** all outputs 0, `pending` = 0, operand latches 0, `last_grant` = N_REQ-1 (so requester 0 wins first), state ST_IDLE. Reset mid-operation drops all pending and in-flight work and produces no done pulse.

## Timing
- `req_start[i]` at edge t: `pending[i]` is visible at t+1.
- If the arbiter is idle, `div_start` is asserted in the cycle after t+1.
- **Divider path:** `req_done` is high in the cycle after the cycle `div_done` is sampled high. Overhead is 3 cycles plus divider latency.
- **Zero-divisor path:** `req_done` is high 3 cycles after `req_start`.
- **Back-to-back:** the next `div_start` comes at the earliest one cycle after the `req_done` pulse, since ST_IDLE takes one cycle.
- At most one `req_done` bit is high in any cycle. `div_start` is never high in two consecutive cycles.
- **Fairness:** with all requesters continuously pending, each is served once per N_REQ grants.

## Structure
- **Shared package `vp2_pkg`:**
  - state encodings ST_IDLE/ST_WAIT/ST_ZERO
  - width constants DIV_W=32, QUO_W=64
  - zero-divide quotient constant QUO_SAT = all ones
- **Sub-module `rr_pick`:** combinational round-robin picker. Inputs `pending[N_REQ]` and `last[log2]`; outputs `valid` and `winner[log2]`. It is reused later for the step-output arbiter.
- Everything else, including the operand latches, lives in `div_arbiter`.

## Test plan
- **Single request, 5-cycle divider model:** `req_start[2]` with 1000/10 → one `div_start` carrying 1000/10; `req_done` = 0100 and `req_quotinent` = 100 (divider-model result) in the cycle after `div_done`; no other done bits.
- **All four requesters pulse in the same cycle, operands i*100/1:** grants in order 0,1,2,3; four done pulses, each with the matching quotient; no `div_start` overlap.
- **Round-robin after grant to 1, requesters 0 and 3 pending:** 3 is served before 0.
- **Zero divisor on requester 1 (500/0):** `div_start` never asserted; `req_done[1]` three cycles after start; quotient all ones.
- **Re-request:**
  - `req_start[0]` again while 0 is in flight → two `req_done[0]` pulses with the two different quotients.
  - Two starts while only pending → one completion, using the second operands.
- **Reset asserted during ST_WAIT, then a late `div_done`:** no `req_done`, outputs 0, next request served normally starting with requester 0.
